float_pt_to_int: RTL



---
 rtl/fp_pkg.sv | 50 +++++
 rtl/float_pt_to_int.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/fp_pkg.sv
// Shared floating-point constants, the converter state encoding and the
// exponent classification helper used by the FP datapath blocks.
package fp_pkg;

  localparam int EXP_W   = 8;
  localparam int MAN_W   = 23;
  localparam int INT_W   = 32;
  localparam int BIAS    = 127;
  localparam int EXP_MAX = 255;
  localparam int CNT_W   = 5;

  localparam logic [INT_W-1:0] INT_MAX = 32'h7FFF_FFFF;
  localparam logic [INT_W-1:0] INT_MIN = 32'h8000_0000;

  // Biased exponent thresholds used by the classifier and the aligner.
  localparam logic [EXP_W-1:0] EXP_ONE   = 8'(BIAS);          // |x| in [1,2)
  localparam logic [EXP_W-1:0] EXP_ALIGN = 8'(BIAS + MAN_W);  // mantissa LSB weighs 1
  localparam logic [EXP_W-1:0] EXP_OVF   = 8'(BIAS + 31);     // |x| >= 2^31
  localparam logic [EXP_W-1:0] EXP_SPEC  = 8'(EXP_MAX);       // Inf / NaN

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_SIGN  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    CLS_ZERO  = 2'd0,  // zero or denormal (flushed)
    CLS_UNDER = 2'd1,  // 0 < |x| < 1
    CLS_OVF   = 2'd2,  // Inf, NaN or |x| >= 2^31
    CLS_NORM  = 2'd3   // 1 <= |x| < 2^31
  } cls_e;

  // Classify an operand by its biased exponent alone.
  function automatic cls_e fp_classify(input logic [EXP_W-1:0] e);
    cls_e c;
    if (e == 8'd0) begin
      c = CLS_ZERO;
    end else if (e < EXP_ONE) begin
      c = CLS_UNDER;
    end else if ((e == EXP_SPEC) || (e >= EXP_OVF)) begin
      c = CLS_OVF;
    end else begin
      c = CLS_NORM;
    end
    return c;
  endfunction

endpackage

// File: rtl/float_pt_to_int.sv
// Sequential single-precision float to signed 32-bit integer converter.
// Truncates toward zero; saturates with ovf on Inf/NaN/out-of-range.
// The mantissa is aligned one bit per cycle, so latency depends on exponent.
module float_pt_to_int
  import fp_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             s_in,
  input  logic [EXP_W-1:0] e_in,
  input  logic [MAN_W-1:0] m_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [INT_W-1:0] int_out,
  output logic             ovf
);

  state_e             state_q, state_d;
  logic [INT_W-1:0]   mag_q, mag_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               dir_left_q, dir_left_d;
  logic               sign_q, sign_d;
  logic [INT_W-1:0]   int_out_q, int_out_d;
  logic               ovf_q, ovf_d;
  logic               out_valid_q;
  logic               in_ready_q;

  // Next-state, aligner and result computation.
  always_comb begin
    state_d    = state_q;
    mag_d      = mag_q;
    cnt_d      = cnt_q;
    dir_left_d = dir_left_q;
    sign_d     = sign_q;
    int_out_d  = int_out_q;
    ovf_d      = ovf_q;

    case (state_q)
      ST_IDLE: begin
        // in_ready is high only here, so in_valid alone is an accept.
        if (in_valid) begin
          case (fp_classify(e_in))
            CLS_ZERO, CLS_UNDER: begin
              int_out_d = 32'd0;
              ovf_d     = 1'b0;
              state_d   = ST_DONE;
            end
            CLS_OVF: begin
              int_out_d = s_in ? INT_MIN : INT_MAX;
              ovf_d     = 1'b1;
              state_d   = ST_DONE;
            end
            CLS_NORM: begin
              mag_d  = {{(INT_W-MAN_W-1){1'b0}}, 1'b1, m_in};
              sign_d = s_in;
              // Below EXP_ALIGN the binary point sits inside the mantissa.
              if (e_in < EXP_ALIGN) begin
                dir_left_d = 1'b0;
                cnt_d      = CNT_W'(EXP_ALIGN - e_in);
              end else begin
                dir_left_d = 1'b1;
                cnt_d      = CNT_W'(e_in - EXP_ALIGN);
              end
              state_d = ST_SHIFT;
            end
            default: begin
              state_d = ST_IDLE;
            end
          endcase
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_SHIFT: begin
        if (cnt_q == 5'd0) begin
          state_d = ST_SIGN;
        end else begin
          // Right shifts drop fraction bits: truncation toward zero.
          if (dir_left_q) begin
            mag_d = {mag_q[INT_W-2:0], 1'b0};
          end else begin
            mag_d = {1'b0, mag_q[INT_W-1:1]};
          end
          cnt_d   = cnt_q - 5'd1;
          state_d = ST_SHIFT;
        end
      end

      ST_SIGN: begin
        int_out_d = sign_q ? (~mag_q + 32'd1) : mag_q;
        ovf_d     = 1'b0;
        state_d   = ST_DONE;
      end

      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, datapath and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      mag_q       <= 32'd0;
      cnt_q       <= 5'd0;
      dir_left_q  <= 1'b0;
      sign_q      <= 1'b0;
      int_out_q   <= 32'd0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      mag_q       <= mag_d;
      cnt_q       <= cnt_d;
      dir_left_q  <= dir_left_d;
      sign_q      <= sign_d;
      int_out_q   <= int_out_d;
      ovf_q       <= ovf_d;
      out_valid_q <= (state_d == ST_DONE);
      in_ready_q  <= (state_d == ST_IDLE);
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign int_out   = int_out_q;
  assign ovf       = ovf_q;

endmodule
